// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch, decode wait, classify, mem/mul wait, WB, trap.
// Ports: clk, rst (sync, active-high); code, br_taken, imem_ack, dmem_ack, mul_done in;
//   imem_req, ir_we, dmem_req, dmem_we, mul_start, rf_we, wb_sel, csr_we,
//   pc_we, pc_sel, trap, trap_cause, state out.
// Build option: FEWCORE_MUL_EN enables the multiply path (MULW state).
module core_ctrl_fsm #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] code,
  input  logic        br_taken,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        mul_done,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        mul_start,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        csr_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        trap,
  output logic [3:0]  trap_cause,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DEC   = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_MULW  = 3'd4,
    S_WB    = 3'd5,
    S_TRAP  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BR, C_JMP, C_MUL, C_CSR
  } cls_e;

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] cause_q, cause_d;

  cls_e       ex_cls;
  logic       ex_trap;
  logic [3:0] ex_cause;
  logic [6:0] op;

  assign op = code[6:0];

  // System ops with code[9:8]==00 are ecall/ebreak (code[7] tells
  // them apart); any other system encoding is a CSR access.
  always_comb begin
    ex_cls   = C_ALU;
    ex_trap  = 1'b0;
    ex_cause = 4'd0;
    if (code == 12'hFFF || op == 7'b0011000) begin
      ex_trap  = 1'b1;
      ex_cause = 4'd2;
    end else if (op == 7'b1110011) begin
      if (code[9:8] == 2'b00) begin
        ex_trap  = 1'b1;
        ex_cause = code[7] ? 4'd3 : 4'd11;
      end else begin
        ex_cls = C_CSR;
      end
    end else if (op == 7'b0000011) begin
      ex_cls = C_LOAD;
    end else if (op == 7'b0100011) begin
      ex_cls = C_STORE;
    end else if (op == 7'b1100011) begin
      ex_cls = C_BR;
    end else if (op == 7'b1101111 || op == 7'b1100111) begin
      ex_cls = C_JMP;
    end else if (op == 7'b0110011 && code[10]) begin
`ifdef FEWCORE_MUL_EN
      ex_cls   = C_MUL;
`else
      ex_trap  = 1'b1;
      ex_cause = 4'd2;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q + 8'd1;
    cause_d = cause_q;
    case (state_q)
      S_DEC: state_d = S_EXEC;
      S_EXEC: begin
        cls_d = ex_cls;
        if (ex_trap) begin
          state_d = S_TRAP;
          cause_d = ex_cause;
        end else if (ex_cls == C_LOAD || ex_cls == C_STORE) begin
          state_d = S_MEM;
        end else if (ex_cls == C_MUL) begin
          state_d = S_MULW;
        end else begin
          state_d = S_WB;
        end
      end
      // Ack on the last allowed cycle still completes normally.
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_TRAP;
          cause_d = (cls_q == C_STORE) ? 4'd7 : 4'd5;
        end
      end
      S_MULW: if (mul_done) state_d = S_WB;
      S_WB:   state_d = S_FETCH;
      S_TRAP: state_d = S_FETCH;
      default: begin
        if (imem_ack) begin
          state_d = S_DEC;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_TRAP;
          cause_d = 4'd1;
        end else begin
          state_d = S_FETCH;
        end
      end
    endcase
    if (state_d != state_q) cnt_d = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_ALU;
      cnt_q   <= 8'd0;
      cause_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    mul_start = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'b00;
    csr_we    = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    trap      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_DEC:  ;
        S_EXEC: begin
`ifdef FEWCORE_MUL_EN
          mul_start = !ex_trap && ex_cls == C_MUL;
`endif
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_STORE);
        end
        S_MULW: ;
        S_WB: begin
          pc_we  = 1'b1;
          pc_sel = (cls_q == C_JMP || (cls_q == C_BR && br_taken))
                   ? 2'b01 : 2'b00;
          rf_we  = !(cls_q == C_STORE || cls_q == C_BR);
          csr_we = (cls_q == C_CSR);
          case (cls_q)
            C_LOAD:  wb_sel = 2'b01;
            C_JMP:   wb_sel = 2'b10;
            C_MUL:   wb_sel = 2'b11;
            default: wb_sel = 2'b00;
          endcase
        end
        S_TRAP: begin
          trap   = 1'b1;
          pc_we  = 1'b1;
          pc_sel = 2'b10;
        end
        default: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
      endcase
    end
  end

  assign trap_cause = rst ? 4'd0 : cause_q;
  assign state      = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Scoreboard bench for core_ctrl_fsm.
// Expected WB/TRAP results are queued per instruction and popped on pc_we.
module tb_core_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] code = 12'h0;
  logic        br_taken = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        mul_done = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we, mul_start;
  logic        rf_we, csr_we, pc_we, trap;
  logic [1:0]  wb_sel, pc_sel;
  logic [3:0]  trap_cause;
  logic [2:0]  state;

  core_ctrl_fsm #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .code(code), .br_taken(br_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .mul_done(mul_done),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .mul_start(mul_start), .rf_we(rf_we),
    .wb_sel(wb_sel), .csr_we(csr_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  always #5 clk = ~clk;

  logic [19:0] outs;
  assign outs = {imem_req, ir_we, dmem_req, dmem_we, mul_start, rf_we,
                 wb_sel, csr_we, pc_we, pc_sel, trap, trap_cause, state};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [10:0] expq[$];
  string       tagq[$];
  logic [3:0]  cz = 4'd0;

  int fetch_dly = 0;
  int dmem_dly = 0;
  int mul_dly = 0;
  bit ack_all = 1'b1;
  int fcnt = 0, dcnt = 0, mcnt = 0;
  int dreq_n = 0, dwe_n = 0, mst_n = 0, ir_n = 0;

  function automatic logic [10:0] rec(logic [1:0] ps, logic rf,
      logic [1:0] ws, logic cw, logic tp, logic [3:0] cs);
    return {ps, rf, ws, cw, tp, cs};
  endfunction

  task automatic push_wb(input string tag, input logic [1:0] ps,
      input logic rf, input logic [1:0] ws, input logic cw);
    expq.push_back(rec(ps, rf, ws, cw, 1'b0, cz));
    tagq.push_back(tag);
  endtask

  task automatic push_trap(input string tag, input logic [3:0] cs);
    cz = cs;
    expq.push_back(rec(2'b10, 1'b0, 2'b00, 1'b0, 1'b1, cs));
    tagq.push_back(tag);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Memory/multiplier model: acks after a programmed number of cycles.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (ack_all) begin
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        mul_done = 1'b1;
        fcnt = 0;
        dcnt = 0;
        mcnt = 0;
      end else begin
        imem_ack = imem_req && (fcnt == fetch_dly);
        fcnt = imem_req ? fcnt + 1 : 0;
        dmem_ack = dmem_req && (dcnt == dmem_dly);
        dcnt = dmem_req ? dcnt + 1 : 0;
        if (dmem_req) dreq_n++;
        if (dmem_req && dmem_we) dwe_n++;
        if (mul_start) begin
          mst_n++;
          mcnt = 1;
        end else if (mcnt != 0) begin
          mcnt++;
        end
        mul_done = (mcnt == mul_dly + 1);
        if (mul_done) mcnt = 0;
      end
    end
  end

  // Scoreboard consumer: every pc_we cycle retires one expected record.
  initial begin
    logic [10:0] e;
    string t;
    forever begin
      @(negedge clk);
      if (ir_we) ir_n++;
      if (pc_we) begin
        if (expq.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = expq.pop_front();
          t = tagq.pop_front();
          chk({"wb_", t},
              {21'd0, pc_sel, rf_we, wb_sel, csr_we, trap, trap_cause},
              {21'd0, e});
        end
      end
    end
  end

  // Entered in the cycle before FETCH (or in FETCH when now=1);
  // returns in the WB/TRAP cycle with the octal state trace checked.
  task automatic run(input string tag, input logic [11:0] c,
      input logic bt, input int fd, input int dd, input int md,
      input logic [31:0] etr, input int en, input bit now);
    logic [31:0] tr;
    int n, ir0;
    fetch_dly = fd;
    dmem_dly = dd;
    mul_dly = md;
    code = c;
    ir0 = ir_n;
    tr = 32'd0;
    n = 0;
    if (!now) tick();
    br_taken = bt;
    forever begin
      tr = (tr << 3) | {29'd0, state};
      n++;
      if (state == 3'd5 || state == 3'd6) break;
      if (n >= 40) begin
        chk({tag, "_timeout"}, 32'd0, 32'd1);
        break;
      end
      tick();
    end
    chk({tag, "_trace"}, tr, etr);
    chk({tag, "_len"}, n, en);
    chk({tag, "_irwe"}, ir_n - ir0, (fd > 50) ? 0 : 1);
  endtask

  initial begin
    int d0, w0, m0;
    tick();
    tick();
    #2;
    chk("rst_outs", {12'd0, outs}, 32'd0);
    tick();
    rst = 1'b0;
    ack_all = 1'b0;

    push_wb("addi", 2'b00, 1'b1, 2'b00, 1'b0);
    run("addi", 12'h013, 1'b0, 0, 0, 0, 32'o0125, 4, 1'b1);

    d0 = dreq_n;
    w0 = dwe_n;
    push_wb("lw", 2'b00, 1'b1, 2'b01, 1'b0);
    run("lw", 12'h103, 1'b0, 0, 2, 0, 32'o0123335, 7, 1'b0);
    chk("lw_req_cycles", dreq_n - d0, 32'd3);
    chk("lw_we_cycles", dwe_n - w0, 32'd0);

    w0 = dwe_n;
    push_wb("sw", 2'b00, 1'b0, 2'b00, 1'b0);
    run("sw", 12'h123, 1'b0, 0, 0, 0, 32'o01235, 5, 1'b0);
    chk("sw_we_cycles", dwe_n - w0, 32'd1);

    push_wb("beq_t", 2'b01, 1'b0, 2'b00, 1'b0);
    run("beq_t", 12'h063, 1'b1, 0, 0, 0, 32'o0125, 4, 1'b0);
    push_wb("beq_nt", 2'b00, 1'b0, 2'b00, 1'b0);
    run("beq_nt", 12'h063, 1'b0, 0, 0, 0, 32'o0125, 4, 1'b0);
    push_wb("jal", 2'b01, 1'b1, 2'b10, 1'b0);
    run("jal", 12'h06F, 1'b0, 0, 0, 0, 32'o0125, 4, 1'b0);
    push_wb("jalr", 2'b01, 1'b1, 2'b10, 1'b0);
    run("jalr", 12'h067, 1'b0, 0, 0, 0, 32'o0125, 4, 1'b0);
    push_wb("csr", 2'b00, 1'b1, 2'b00, 1'b1);
    run("csr", 12'h173, 1'b0, 0, 0, 0, 32'o0125, 4, 1'b0);

    push_trap("illegal", 4'd2);
    run("illegal", 12'hFFF, 1'b0, 0, 0, 0, 32'o0126, 4, 1'b0);
    push_wb("addi_held", 2'b00, 1'b1, 2'b00, 1'b0);
    run("addi_held", 12'h013, 1'b0, 0, 0, 0, 32'o0125, 4, 1'b0);
    push_trap("ebreak", 4'd3);
    run("ebreak", 12'h0F3, 1'b0, 0, 0, 0, 32'o0126, 4, 1'b0);
    push_trap("ecall", 4'd11);
    run("ecall", 12'h073, 1'b0, 0, 0, 0, 32'o0126, 4, 1'b0);
    push_trap("irq", 4'd2);
    run("irq", 12'h018, 1'b0, 0, 0, 0, 32'o0126, 4, 1'b0);

    push_trap("ifetch_to", 4'd1);
    run("ifetch_to", 12'h013, 1'b0, 99, 0, 0, 32'o00006, 5, 1'b0);
    push_wb("ifetch_last", 2'b00, 1'b1, 2'b00, 1'b0);
    run("ifetch_last", 12'h013, 1'b0, 3, 0, 0, 32'o0000125, 7, 1'b0);
    push_trap("load_to", 4'd5);
    run("load_to", 12'h103, 1'b0, 0, 99, 0, 32'o01233336, 8, 1'b0);
    push_wb("store_last", 2'b00, 1'b0, 2'b00, 1'b0);
    run("store_last", 12'h123, 1'b0, 0, 3, 0, 32'o01233335, 8, 1'b0);
    push_trap("store_to", 4'd7);
    run("store_to", 12'h123, 1'b0, 0, 99, 0, 32'o01233336, 8, 1'b0);

    m0 = mst_n;
`ifdef FEWCORE_MUL_EN
    push_wb("mul", 2'b00, 1'b1, 2'b11, 1'b0);
    run("mul", 12'h433, 1'b0, 0, 0, 3, 32'o0124445, 7, 1'b0);
    chk("mul_start_n", mst_n - m0, 32'd1);
`else
    push_trap("mul", 4'd2);
    run("mul", 12'h433, 1'b0, 0, 0, 3, 32'o0126, 4, 1'b0);
    chk("mul_start_n", mst_n - m0, 32'd0);
`endif

    fetch_dly = 0;
    dmem_dly = 99;
    code = 12'h103;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state == 3'd3) break;
    end
    chk("mem_reached", {29'd0, state}, 32'd3);
    rst = 1'b1;
    #2;
    chk("rst_mem_outs", {12'd0, outs}, 32'd0);
    tick();
    rst = 1'b0;
    cz = 4'd0;
    push_wb("post_rst", 2'b00, 1'b1, 2'b00, 1'b0);
    run("post_rst", 12'h013, 1'b0, 0, 0, 0, 32'o0125, 4, 1'b1);

    tick();
    tick();
    chk("sb_leftover", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
